// File: rtl/adc_sample_packer.sv
// adc_sample_packer: packs pairs of 16-bit ADC samples into 32-bit words and
// buffers them in a first-word-fall-through FIFO that raises a DMA request
// once a burst is stored, or whenever capture stops with data left over.
module adc_sample_packer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  output logic [31:0]              out_data,
  output logic                     out_req,
  input  logic                     out_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     pack_pending,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

  pack_state_t   state;
  pack_state_t   state_d;
  logic [15:0]   low_q;
  logic [15:0]   low_d;
  logic          wr_req_c;
  logic [31:0]   wr_word_c;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full_c;
  logic          empty_c;
  logic          pop_c;
  logic          wr_accept_c;
  logic          overflow_set_c;
  logic          underflow_set_c;

  // Packer state register; clear abandons any held low half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      low_q <= '0;
    end else if (clear) begin
      state <= EMPTY;
      low_q <= '0;
    end else begin
      state <= state_d;
      low_q <= low_d;
    end
  end

  // Packer next state and word generation; a falling enable pads the held half.
  always_comb begin
    state_d   = state;
    low_d     = low_q;
    wr_req_c  = 1'b0;
    wr_word_c = '0;
    case (state)
      EMPTY: begin
        if (enable && in_valid) begin
          low_d   = in_data;
          state_d = HALF;
        end
      end
      HALF: begin
        if (!enable) begin
          wr_req_c  = 1'b1;
          wr_word_c = {16'h0000, low_q};
          state_d   = EMPTY;
        end else if (in_valid) begin
          wr_req_c  = 1'b1;
          wr_word_c = {in_data, low_q};
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Write acceptance is judged on the pre-pop level, so a full FIFO popped in
  // the same cycle still takes the new word.
  always_comb begin
    full_c          = (level == LW'(DEPTH));
    empty_c         = (level == '0);
    pop_c           = out_ack && !empty_c;
    wr_accept_c     = wr_req_c && (!full_c || out_ack);
    overflow_set_c  = wr_req_c && full_c && !out_ack;
    underflow_set_c = out_ack && empty_c;
  end

  // Pointers, level and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)       rd_ptr <= rd_ptr + PW'(1);
      case ({wr_accept_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (overflow_set_c)  overflow  <= 1'b1;
      if (underflow_set_c) underflow <= 1'b1;
    end
  end

  // Word storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept_c && !clear) mem[wr_ptr] <= wr_word_c;
  end

  assign out_data     = mem[rd_ptr];
  assign pack_pending = (state == HALF);
  assign out_req      = (level >= LW'(BURST)) || (!enable && (level != '0));

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer (DEPTH=16, BURST=4).
module tb_adc_sample_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic [31:0] out_data;
  logic        out_req;
  logic        out_ack;
  logic [4:0]  level;
  logic        pack_pending;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] head;

  adc_sample_packer #(.DEPTH(16), .BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_data     (out_data),
    .out_req      (out_req),
    .out_ack      (out_ack),
    .level        (level),
    .pack_pending (pack_pending),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      push(16'(2 * i));
      push(16'(2 * i + 1));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ack = 1'b0;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_req", 32'(out_req), 32'd0);
    check("rst_pend", 32'(pack_pending), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Capture and drain
    enable = 1'b1;
    push(16'hABCD);
    check("cap_pend", 32'(pack_pending), 32'd1);
    push(16'h1234);
    check("cap_lvl1", 32'(level), 32'd1);
    check("cap_pend0", 32'(pack_pending), 32'd0);
    check("cap_head", out_data, 32'h1234ABCD);
    push(16'hAA55); push(16'h3C41);
    check("cap_lvl2", 32'(level), 32'd2);
    push(16'h0000); push(16'hABCD);
    check("cap_lvl3", 32'(level), 32'd3);
    check("cap_req3", 32'(out_req), 32'd0);
    push(16'h5678); push(16'h9ABC);
    check("cap_lvl4", 32'(level), 32'd4);
    check("cap_req4", 32'(out_req), 32'd1);
    out_ack = 1'b1;
    check("drain0", out_data, 32'h1234ABCD); tick();
    check("drain1", out_data, 32'h3C41AA55); tick();
    check("drain2", out_data, 32'hABCD0000); tick();
    check("drain3", out_data, 32'h9ABC5678); tick();
    out_ack = 1'b0;
    check("drain_lvl", 32'(level), 32'd0);
    check("drain_req", 32'(out_req), 32'd0);
    check("drain_udf", 32'(underflow), 32'd0);

    // Pad on stop; a strobe in the falling-enable cycle is ignored
    push(16'h1111); push(16'h2222); push(16'hAA55);
    check("pad_pend1", 32'(pack_pending), 32'd1);
    enable = 1'b0;
    push(16'hFFFF);
    check("pad_pend0", 32'(pack_pending), 32'd0);
    check("pad_lvl", 32'(level), 32'd2);
    check("pad_req", 32'(out_req), 32'd1);
    push(16'hEEEE);
    check("pad_idle_pend", 32'(pack_pending), 32'd0);
    check("pad_idle_lvl", 32'(level), 32'd2);
    out_ack = 1'b1;
    check("pad_w0", out_data, 32'h22221111); tick();
    check("pad_w1", out_data, 32'h0000AA55); tick();
    out_ack = 1'b0;
    check("pad_lvl0", 32'(level), 32'd0);
    check("pad_req0", 32'(out_req), 32'd0);

    // Full boundary: 17th word dropped
    pulse_clear();
    enable = 1'b1;
    fill16();
    check("full_lvl", 32'(level), 32'd16);
    check("full_req", 32'(out_req), 32'd1);
    push(16'hDEAD); push(16'hBEEF);
    check("ovf_lvl", 32'(level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", out_data, 32'h00010000);
    check("ovf_pend", 32'(pack_pending), 32'd0);
    pulse_clear();
    check("clr_lvl", 32'(level), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full boundary: 17th word accepted alongside a pop
    fill16();
    push(16'hDEAD);
    in_valid = 1'b1; in_data = 16'hBEEF; out_ack = 1'b1;
    tick();
    in_valid = 1'b0; out_ack = 1'b0;
    check("wp_lvl", 32'(level), 32'd16);
    check("wp_ovf", 32'(overflow), 32'd0);
    check("wp_head", out_data, 32'h00030002);
    out_ack = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("wp_pop", out_data, {16'(2 * i + 1), 16'(2 * i)});
      tick();
    end
    check("wp_last", out_data, 32'hBEEFDEAD);
    tick();
    out_ack = 1'b0;
    check("wp_lvl0", 32'(level), 32'd0);

    // Underflow
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_lvl", 32'(level), 32'd0);
    pulse_clear();
    check("udf_clr", 32'(underflow), 32'd0);

    // Wrap-around streaming with interleaved pops
    for (int w = 0; w < 40; w++) begin
      push(16'(16'h1000 + w));
      in_valid = 1'b1;
      in_data  = 16'(16'h8000 + w);
      if (w >= 3) begin
        head = exp_q.pop_front();
        check("wrap_pop", out_data, head);
        out_ack = 1'b1;
      end
      tick();
      in_valid = 1'b0; out_ack = 1'b0;
      exp_q.push_back({16'(16'h8000 + w), 16'(16'h1000 + w)});
    end
    check("wrap_lvl", 32'(level), 32'd3);
    out_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      head = exp_q.pop_front();
      check("wrap_tail", out_data, head);
      tick();
    end
    out_ack = 1'b0;
    check("wrap_lvl0", 32'(level), 32'd0);
    check("wrap_ovf", 32'(overflow), 32'd0);
    check("wrap_udf", 32'(underflow), 32'd0);

    // Mid-operation abort by reset
    for (int i = 0; i < 7; i++) push(16'(i));
    check("ab_lvl", 32'(level), 32'd3);
    check("ab_pend", 32'(pack_pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ab_rst_lvl", 32'(level), 32'd0);
    check("ab_rst_pend", 32'(pack_pending), 32'd0);
    check("ab_rst_req", 32'(out_req), 32'd0);
    check("ab_rst_ovf", 32'(overflow), 32'd0);
    check("ab_rst_udf", 32'(underflow), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Mid-operation abort by clear, with the would-be pad cycle discarded
    for (int i = 0; i < 7; i++) push(16'(i));
    check("ab2_lvl", 32'(level), 32'd3);
    clear = 1'b1; enable = 1'b0;
    check("ab2_hold", 32'(level), 32'd3);
    tick();
    clear = 1'b0;
    check("ab2_lvl0", 32'(level), 32'd0);
    check("ab2_pend", 32'(pack_pending), 32'd0);
    check("ab2_req", 32'(out_req), 32'd0);
    tick();
    check("ab2_nopad", 32'(level), 32'd0);
    check("ab2_ovf", 32'(overflow), 32'd0);
    enable = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

Sample packing FIFO between the AD7984 capture block and SDMA channel 0. It accepts 16-bit conversion results on a valid strobe and packs sample pairs into 32-bit words. Packed words are buffered in a first-word-fall-through FIFO, and a DMA request is raised once a burst's worth of words is stored. It replaces the zero-extended 16-bit path into the SDMA, halving bus transfers per sample.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of two, at least 2.
- BURST, 4, FIFO level at or above which OUT_REQ asserts; 1 to DEPTH.

Ports:
- CLK  input  1  single clock for all logic.
- RST  input  1  asynchronous, active-high reset.
- ENABLE  input  1  accept samples while high.
- CLEAR  input  1  synchronous flush; highest priority.
- IN_VALID  input  1  one-cycle strobe, IN_DATA valid.
- IN_DATA  input  16  ADC sample.
- OUT_DATA  output  32  FIFO head word; meaningful only while LEVEL > 0.
- OUT_REQ  output  1  DMA request.
- OUT_ACK  input  1  pops one word per high cycle.
- LEVEL  output  clog2(DEPTH)+1  stored word count, 0..DEPTH.
- PACK_PENDING  output  1  a low half-word is held awaiting its partner.
- OVERFLOW  output  1  sticky; a completed word was dropped.
- UNDERFLOW  output  1  sticky; OUT_ACK arrived while LEVEL = 0.

## Operation
- Packer states are EMPTY and HALF. PACK_PENDING is high exactly in HALF.
- In EMPTY with ENABLE and IN_VALID:
  - IN_DATA is latched as the low half.
  - State moves to HALF.
- In HALF with ENABLE and IN_VALID:
  - The word {IN_DATA, low half} is written to the FIFO.
  - State moves to EMPTY.
- ENABLE low in HALF (including the cycle it falls):
  - The pad word {16'h0000, low half} is written.
  - State moves to EMPTY.
  - IN_VALID is ignored in that cycle.
- ENABLE low in EMPTY: IN_VALID is ignored.
- Write acceptance is judged on LEVEL before any pop in the same cycle:
  - LEVEL < DEPTH: the word is accepted.
  - LEVEL = DEPTH with OUT_ACK high: the word is accepted; the pop and the write both occur and LEVEL is unchanged.
  - LEVEL = DEPTH with OUT_ACK low: the word is dropped, OVERFLOW is set, and the packer still returns to EMPTY.
- Pop: OUT_ACK high with LEVEL > 0 advances the read pointer. OUT_ACK high with LEVEL = 0 changes nothing except setting UNDERFLOW.
- LEVEL update each cycle: +1 for an accepted write, -1 for a valid pop, unchanged when both occur.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full versus empty is resolved by LEVEL, not by pointer comparison.
- OUT_REQ = (LEVEL >= BURST) or (ENABLE low and LEVEL > 0), so a stopped capture drains its partial burst.
- OUT_DATA is the memory word at the read pointer (first-word fall-through). Memory contents are not reset.
- OVERFLOW and UNDERFLOW are cleared only by CLEAR or RST.
- CLEAR high, on the next edge:
  - Pointers, LEVEL, packer state and both flags go to zero.
  - Any write, pop or pad in that cycle is discarded.

## Timing
- Reset values: OUT_REQ 0, LEVEL 0, PACK_PENDING 0, OVERFLOW 0, UNDERFLOW 0. OUT_DATA is undefined.
- RST assertion takes effect immediately, asynchronously, and aborts any half-packed sample.
- Latency from second sample to stored word: the word is written on the edge that samples the second IN_VALID. LEVEL, OUT_DATA and OUT_REQ reflect it in the following cycle.
- OUT_REQ is combinational from registered LEVEL and ENABLE; no other combinational paths.
- OUT_DATA changes in the cycle after a pop edge. The consumer samples OUT_DATA in the same cycle it asserts OUT_ACK.
- Back-to-back IN_VALID on every cycle is supported, giving one word per two cycles. Back-to-back OUT_ACK is supported, giving one pop per cycle.
- Flag updates appear one cycle after the offending event.

## Test plan
- Capture and drain: DEPTH=16, BURST=4; feed ABCD, 1234, AA55, 3C41, then 0000 and ABCD in the same pattern (eight samples total).
  - LEVEL must step 1, 2, 3, 4.
  - OUT_REQ must rise the cycle after the 4th word.
  - Popping must give 1234ABCD, 3C41AA55, ABCD0000, ...
- Pad on stop: feed 3 samples, then drop ENABLE.
  - Second word must be 0000AA55.
  - PACK_PENDING must return to 0.
  - OUT_REQ must assert with LEVEL = 2 and drain both words.
- Full boundary:
  - Fill 16 words, then complete a 17th with OUT_ACK low: LEVEL stays 16, OVERFLOW = 1, and the head word is unchanged.
  - Repeat the 17th with OUT_ACK high in the write cycle: the word is accepted, LEVEL stays 16, OVERFLOW stays 0 (fresh run), and the last pop returns the 17th word.
- Underflow: OUT_ACK with LEVEL = 0.
  - UNDERFLOW = 1 and LEVEL stays 0.
  - A subsequent CLEAR zeroes the flag.
- Wrap-around: stream 40 words with interleaved pops keeping LEVEL between 1 and 6.
  - Popped words must match the pushed order exactly.
  - No flags set.
- Mid-operation abort:
  - In HALF with LEVEL = 3, assert RST: all outputs return to reset values immediately.
  - Repeat with CLEAR in place of RST: the same values appear after one edge, and no pad word is written.
